// File: rtl/cache_nc_bypass.sv
// rtl/cache_nc_bypass.sv - non-cacheable bypass, DRAM request arbiter and flush walker
// Uncached words become line requests tagged for steering; DRAM responses are split between cache and bypass.
module cache_nc_bypass #(
  parameter int CACHE_LINE_SIZE = 64,
  parameter int WORD_SIZE       = 4,
  parameter int NUM_LINES       = 256,
  parameter int CORE_TAG_WIDTH  = 4,
  parameter int DRAM_TAG_WIDTH  = 26,
  parameter int PENDING_SIZE    = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush,
  output logic                                    flush_valid,
  output logic [$clog2(NUM_LINES)-1:0]            flush_addr,
  input  logic                                    flush_ready,
  output logic                                    flush_done,
  input  logic                                    bypass_req_valid,
  input  logic                                    bypass_req_rw,
  input  logic [WORD_SIZE-1:0]                    bypass_req_byteen,
  input  logic [32-$clog2(WORD_SIZE)-1:0]         bypass_req_addr,
  input  logic [WORD_SIZE*8-1:0]                  bypass_req_data,
  input  logic [CORE_TAG_WIDTH-1:0]               bypass_req_tag,
  output logic                                    bypass_req_ready,
  output logic                                    bypass_rsp_valid,
  output logic [WORD_SIZE*8-1:0]                  bypass_rsp_data,
  output logic [CORE_TAG_WIDTH-1:0]               bypass_rsp_tag,
  input  logic                                    bypass_rsp_ready,
  input  logic                                    cache_dram_req_valid,
  input  logic                                    cache_dram_req_rw,
  input  logic [CACHE_LINE_SIZE-1:0]              cache_dram_req_byteen,
  input  logic [32-$clog2(CACHE_LINE_SIZE)-1:0]   cache_dram_req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]            cache_dram_req_data,
  input  logic [DRAM_TAG_WIDTH-1:0]               cache_dram_req_tag,
  output logic                                    cache_dram_req_ready,
  output logic                                    cache_dram_rsp_valid,
  output logic [CACHE_LINE_SIZE*8-1:0]            cache_dram_rsp_data,
  output logic [DRAM_TAG_WIDTH-1:0]               cache_dram_rsp_tag,
  input  logic                                    cache_dram_rsp_ready,
  output logic                                    dram_req_valid,
  output logic                                    dram_req_rw,
  output logic [CACHE_LINE_SIZE-1:0]              dram_req_byteen,
  output logic [32-$clog2(CACHE_LINE_SIZE)-1:0]   dram_req_addr,
  output logic [CACHE_LINE_SIZE*8-1:0]            dram_req_data,
  output logic [DRAM_TAG_WIDTH:0]                 dram_req_tag,
  input  logic                                    dram_req_ready,
  input  logic                                    dram_rsp_valid,
  input  logic [CACHE_LINE_SIZE*8-1:0]            dram_rsp_data,
  input  logic [DRAM_TAG_WIDTH:0]                 dram_rsp_tag,
  output logic                                    dram_rsp_ready
);

  localparam int LW   = CACHE_LINE_SIZE * 8;
  localparam int WB   = WORD_SIZE * 8;
  localparam int WPL  = CACHE_LINE_SIZE / WORD_SIZE;
  localparam int WOFF = $clog2(WPL);
  localparam int LA   = 32 - $clog2(CACHE_LINE_SIZE);
  localparam int WA   = 32 - $clog2(WORD_SIZE);
  localparam int FA   = $clog2(NUM_LINES);
  localparam int PW   = (PENDING_SIZE > 1) ? $clog2(PENDING_SIZE) : 1;

  typedef enum logic {F_IDLE = 1'b0, F_WALK = 1'b1} fstate_t;

  fstate_t         fstate, fstate_n;
  logic [FA-1:0]   fctr;

  always_ff @(posedge clk) begin
    if (reset) fstate <= F_WALK;
    else       fstate <= fstate_n;
  end

  always_comb begin
    fstate_n = fstate;
    if (flush)
      fstate_n = F_WALK;
    else if (fstate == F_WALK && flush_ready && fctr == FA'(NUM_LINES - 1))
      fstate_n = F_IDLE;
  end

  always_comb begin
    flush_valid = (fstate == F_WALK);
    flush_done  = (fstate == F_IDLE);
    flush_addr  = fctr;
  end

  always_ff @(posedge clk) begin
    if (reset || flush)               fctr <= '0;
    else if (flush_valid && flush_ready) fctr <= fctr + 1'b1;
  end

  // Pending read table: remembers core tag and word offset per outstanding slot
  logic [PENDING_SIZE-1:0]    pend_valid;
  logic [CORE_TAG_WIDTH-1:0]  pend_tag [PENDING_SIZE];
  logic [WOFF-1:0]            pend_off [PENDING_SIZE];
  logic                       free_any;
  logic [PW-1:0]              free_slot;

  always_comb begin
    free_any  = 1'b0;
    free_slot = '0;
    for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
      if (!pend_valid[i]) begin
        free_any  = 1'b1;
        free_slot = PW'(i);
      end
    end
  end

  logic [WOFF-1:0]            req_off;
  logic [CACHE_LINE_SIZE-1:0] bp_byteen;
  logic [LW-1:0]              bp_data;
  logic [PW-1:0]              bp_slot;
  logic [DRAM_TAG_WIDTH:0]    bp_tag;

  always_comb begin
    req_off   = bypass_req_addr[WOFF-1:0];
    bp_byteen = CACHE_LINE_SIZE'(bypass_req_byteen) << (req_off * WORD_SIZE);
    bp_data   = {WPL{bypass_req_data}};
    bp_slot   = bypass_req_rw ? '0 : free_slot;
    bp_tag    = {1'b1, DRAM_TAG_WIDTH'(bp_slot)};
  end

  logic prio_bypass;
  logic cache_elig, bypass_elig, grant_cache, grant_bypass, load_en;
  logic cache_fire, bypass_fire;

  always_comb begin
    cache_elig   = cache_dram_req_valid;
    bypass_elig  = bypass_req_valid && flush_done && (bypass_req_rw || free_any);
    grant_cache  = cache_elig && (!bypass_elig || !prio_bypass);
    grant_bypass = bypass_elig && (!cache_elig || prio_bypass);
    load_en      = !dram_req_valid || dram_req_ready;
    cache_fire   = grant_cache && load_en;
    bypass_fire  = grant_bypass && load_en;
    cache_dram_req_ready = cache_fire;
    bypass_req_ready     = bypass_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dram_req_valid <= 1'b0;
      prio_bypass    <= 1'b0;
    end else begin
      if (load_en) begin
        dram_req_valid <= cache_fire || bypass_fire;
        if (cache_fire) begin
          dram_req_rw     <= cache_dram_req_rw;
          dram_req_byteen <= cache_dram_req_byteen;
          dram_req_addr   <= cache_dram_req_addr;
          dram_req_data   <= cache_dram_req_data;
          dram_req_tag    <= {1'b0, cache_dram_req_tag};
        end else if (bypass_fire) begin
          dram_req_rw     <= bypass_req_rw;
          dram_req_byteen <= bp_byteen;
          dram_req_addr   <= LA'(bypass_req_addr[WA-1:WOFF]);
          dram_req_data   <= bp_data;
          dram_req_tag    <= bp_tag;
        end
      end
      if (cache_fire)       prio_bypass <= 1'b1;
      else if (bypass_fire) prio_bypass <= 1'b0;
    end
  end

  logic          rsp_is_bypass, rsp_fire;
  logic [PW-1:0] rsp_slot;

  always_comb begin
    rsp_is_bypass        = dram_rsp_tag[DRAM_TAG_WIDTH];
    rsp_slot             = dram_rsp_tag[PW-1:0];
    cache_dram_rsp_valid = dram_rsp_valid && !rsp_is_bypass;
    cache_dram_rsp_data  = dram_rsp_data;
    cache_dram_rsp_tag   = dram_rsp_tag[DRAM_TAG_WIDTH-1:0];
    dram_rsp_ready       = rsp_is_bypass ? (!bypass_rsp_valid || bypass_rsp_ready)
                                         : cache_dram_rsp_ready;
    rsp_fire             = dram_rsp_valid && rsp_is_bypass && dram_rsp_ready;
  end

  // Free happens before allocate so a slot freed this cycle is not reused until next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= '0;
    end else begin
      if (rsp_fire)
        pend_valid[rsp_slot] <= 1'b0;
      if (bypass_fire && !bypass_req_rw) begin
        pend_valid[free_slot] <= 1'b1;
        pend_tag[free_slot]   <= bypass_req_tag;
        pend_off[free_slot]   <= req_off;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bypass_rsp_valid <= 1'b0;
    end else if (rsp_fire) begin
      bypass_rsp_valid <= 1'b1;
      bypass_rsp_data  <= dram_rsp_data[pend_off[rsp_slot] * WB +: WB];
      bypass_rsp_tag   <= pend_tag[rsp_slot];
    end else if (bypass_rsp_ready) begin
      bypass_rsp_valid <= 1'b0;
    end
  end

endmodule
